// File: rtl/l1_mem_responder.sv
// l1_mem_responder: cache-line memory model on the L1 arbiter's external port.
// Accepts one line load/store at a time, services it from a line-wide backing
// array after LATENCY cycles and returns a single response echoing tag/opcode.
module l1_mem_responder #(
  parameter int         LG_LINES           = 10,
  parameter int         LATENCY            = 4,
  parameter logic [4:0] OP_LD              = 5'd4,
  parameter logic [4:0] OP_ST              = 5'd7,
  parameter int         LG_L1D_CL_LEN      = 4,
  parameter int         M_WIDTH            = 32,
  parameter int         LG_MEM_TAG_ENTRIES = 4,
  parameter int         CL_BITS            = 1 << (LG_L1D_CL_LEN + 3)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_req_valid,
  input  logic [M_WIDTH-1:0]            mem_req_addr,
  input  logic [CL_BITS-1:0]            mem_req_store_data,
  input  logic [LG_MEM_TAG_ENTRIES-1:0] mem_req_tag,
  input  logic [4:0]                    mem_req_opcode,
  output logic                          mem_req_ack,
  output logic                          mem_rsp_valid,
  output logic [CL_BITS-1:0]            mem_rsp_load_data,
  output logic [LG_MEM_TAG_ENTRIES-1:0] mem_rsp_tag,
  output logic [4:0]                    mem_rsp_opcode,
  output logic                          bad_opcode,
  output logic [31:0]                   req_count
);

  localparam int NUM_LINES = 1 << LG_LINES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                        state_reg;
  state_t                        state_next;
  logic [7:0]                    cnt_reg;
  logic [7:0]                    cnt_next;
  logic                          ack_reg;
  logic                          ack_next;
  logic                          rsp_valid_reg;
  logic                          rsp_valid_next;
  logic [LG_LINES-1:0]           idx_reg;
  logic [LG_MEM_TAG_ENTRIES-1:0] tag_reg;
  logic [4:0]                    op_reg;
  logic                          bad_reg;
  logic [31:0]                   req_count_reg;
  logic [CL_BITS-1:0]            load_data_reg;

  logic                          accept;
  logic                          rd_en;
  logic                          store_en;
  logic                          op_known;
  logic [LG_LINES-1:0]           req_idx;

  // Byte-offset bits and bits above the line index are deliberately ignored:
  // addresses alias modulo the number of lines in the array.
  logic                          unused_addr_bits;

  logic [CL_BITS-1:0]            mem_array [0:NUM_LINES-1];

  assign req_idx          = mem_req_addr[LG_L1D_CL_LEN +: LG_LINES];
  assign unused_addr_bits = ^mem_req_addr;
  assign op_known         = (mem_req_opcode == OP_LD) || (mem_req_opcode == OP_ST);
  assign store_en         = accept && (mem_req_opcode == OP_ST);

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ack_next       = 1'b0;
    rsp_valid_next = 1'b0;
    accept         = 1'b0;
    rd_en          = 1'b0;
    case (state_reg)
      IDLE: begin
        // Any valid seen here is a new request, including one held over
        // from the RESP cycle, so back-to-back traffic needs no extra gap.
        if (mem_req_valid) begin
          accept     = 1'b1;
          ack_next   = 1'b1;
          cnt_next   = 8'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 8'd0) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          // Only real loads read the array; stores and unknown opcodes
          // respond with zero data.
          rd_en          = (op_reg == OP_LD);
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, handshake pulses, latched request fields and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      ack_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      idx_reg       <= '0;
      tag_reg       <= '0;
      op_reg        <= 5'd0;
      bad_reg       <= 1'b0;
      req_count_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ack_reg       <= ack_next;
      rsp_valid_reg <= rsp_valid_next;
      if (accept) begin
        idx_reg <= req_idx;
        tag_reg <= mem_req_tag;
        op_reg  <= mem_req_opcode;
        if (!op_known) begin
          bad_reg <= 1'b1;
        end
      end
      // Counts responses; the 32-bit add wraps naturally to zero.
      if (state_reg == RESP) begin
        req_count_reg <= req_count_reg + 32'd1;
      end
    end
  end

  // Response data register: holds the line only during the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_data_reg <= '0;
    end else if (rd_en) begin
      load_data_reg <= mem_array[idx_reg];
    end else begin
      load_data_reg <= '0;
    end
  end

  // Backing array write port; stores land at the acceptance edge and the
  // array contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_array[req_idx] <= mem_req_store_data;
    end
  end

  assign mem_req_ack       = ack_reg;
  assign mem_rsp_valid     = rsp_valid_reg;
  assign mem_rsp_load_data = load_data_reg;
  assign mem_rsp_tag       = tag_reg;
  assign mem_rsp_opcode    = op_reg;
  assign bad_opcode        = bad_reg;
  assign req_count         = req_count_reg;

endmodule
